// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU pipeline: operator encodings, format
// widths and the execute-stage state encoding.
package fpu_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam int BIAS   = 127;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        MUL  = 2'b10,
        DONE = 2'b11
    } exec_state_t;

endpackage

// File: rtl/fpu_mul_seq.sv
// Iterative radix-2 shift-add mantissa multiplier. One multiplier bit is
// consumed per cycle, LSB first, for exactly MANT_W cycles. The done flag
// is high during the final iteration and product then carries the exact
// full-width result, so the caller can register it on that same edge.
module fpu_mul_seq #(
    parameter int MANT_W = fpu_pkg::MANT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MANT_W-1:0]     multiplicand,
    input  logic [MANT_W-1:0]     multiplier,
    output logic                  busy,
    output logic                  done,
    output logic [2*MANT_W-1:0]   product
);

    localparam logic [4:0] LAST_CNT = 5'(MANT_W - 1);

    logic [2*MANT_W-1:0] mcand_r;
    logic [MANT_W-1:0]   mplier_r;
    logic [2*MANT_W-1:0] acc_r;
    logic [4:0]          count_r;
    logic                busy_r;
    logic [2*MANT_W-1:0] acc_next_s;
    logic                last_s;

    // Next partial sum and final-iteration detection.
    always_comb begin
        acc_next_s = acc_r;
        last_s     = 1'b0;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
        if (busy_r && (count_r == LAST_CNT)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Operand load on start, then one shift-add step per cycle while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= '0;
            mplier_r <= '0;
            acc_r    <= '0;
            count_r  <= 5'd0;
            busy_r   <= 1'b0;
        end else if (start) begin
            mcand_r  <= {{MANT_W{1'b0}}, multiplicand};
            mplier_r <= multiplier;
            acc_r    <= '0;
            count_r  <= 5'd0;
            busy_r   <= 1'b1;
        end else if (busy_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= {mcand_r[2*MANT_W-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[MANT_W-1:1]};
            count_r  <= count_r + 5'd1;
            if (last_s) begin
                busy_r <= 1'b0;
            end else begin
                busy_r <= 1'b1;
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign busy    = busy_r;
    assign done    = last_s;
    assign product = acc_next_s;

endmodule

// File: rtl/fpu_execute.sv
// Mantissa-arithmetic stage of the FPU pipeline. Add/subtract resolve in a
// single cycle from captured operands; multiply is delegated to the
// iterative shift-add unit. Results are held in DONE until downstream
// accepts them.
module fpu_execute
    import fpu_pkg::*;
#(
    parameter int MANT_W = fpu_pkg::MANT_W,
    parameter int EXP_W  = fpu_pkg::EXP_W,
    parameter int BIAS   = fpu_pkg::BIAS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  sign_1,
    input  logic                  sign_2,
    input  logic [EXP_W-1:0]      exponent,
    input  logic [MANT_W-1:0]     mantissa_1,
    input  logic [MANT_W-1:0]     mantissa_2,
    input  logic [1:0]            operator,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sign,
    output logic [EXP_W+1:0]      out_exponent,
    output logic [2*MANT_W-1:0]   out_mantissa,
    output logic                  out_invalid_op
);

    exec_state_t          state_r;
    logic                 in_ready_r;
    logic                 out_valid_r;
    logic                 out_sign_r;
    logic [EXP_W+1:0]     out_exponent_r;
    logic [2*MANT_W-1:0]  out_mantissa_r;
    logic                 out_invalid_op_r;

    logic                 sign_1_r;
    logic                 sign_2_r;
    logic [EXP_W-1:0]     exp_r;
    logic [MANT_W-1:0]    m1_r;
    logic [MANT_W-1:0]    m2_r;
    logic [1:0]           op_r;

    logic                 accept_s;
    logic                 mul_start_s;
    logic                 mul_busy_s;
    logic                 mul_done_s;
    logic [2*MANT_W-1:0]  mul_product_s;

    logic                 op_is_sub_s;
    logic                 eff_sub_s;
    logic [MANT_W:0]      add_res_s;
    logic                 add_sign_s;

    // Handshake qualification; a multiply loads the iterative unit directly
    // from the input bus on the accepting edge.
    always_comb begin
        accept_s    = in_valid && in_ready_r;
        mul_start_s = 1'b0;
        if (accept_s && (operator == OP_MUL)) begin
            mul_start_s = 1'b1;
        end else begin
            mul_start_s = 1'b0;
        end
    end

    fpu_mul_seq #(
        .MANT_W (MANT_W)
    ) u_mul_seq (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (mul_start_s),
        .multiplicand (mantissa_1),
        .multiplier   (mantissa_2),
        .busy         (mul_busy_s),
        .done         (mul_done_s),
        .product      (mul_product_s)
    );

    // Sign-magnitude add/subtract: the larger magnitude always minuend so
    // the difference stays non-negative; an exact zero is reported positive.
    always_comb begin
        op_is_sub_s = (op_r == OP_SUB);
        eff_sub_s   = sign_1_r ^ sign_2_r ^ op_is_sub_s;
        add_res_s   = '0;
        add_sign_s  = 1'b0;
        if (!eff_sub_s) begin
            add_res_s  = {1'b0, m1_r} + {1'b0, m2_r};
            add_sign_s = sign_1_r;
        end else if (m1_r >= m2_r) begin
            add_res_s  = {1'b0, m1_r} - {1'b0, m2_r};
            add_sign_s = sign_1_r;
        end else begin
            add_res_s  = {1'b0, m2_r} - {1'b0, m1_r};
            add_sign_s = sign_2_r ^ op_is_sub_s;
        end
        if (add_res_s == '0) begin
            add_sign_s = 1'b0;
        end else begin
            add_sign_s = add_sign_s;
        end
    end

    // Execute FSM with operand capture and registered result/handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= IDLE;
            in_ready_r       <= 1'b1;
            out_valid_r      <= 1'b0;
            out_sign_r       <= 1'b0;
            out_exponent_r   <= '0;
            out_mantissa_r   <= '0;
            out_invalid_op_r <= 1'b0;
            sign_1_r         <= 1'b0;
            sign_2_r         <= 1'b0;
            exp_r            <= '0;
            m1_r             <= '0;
            m2_r             <= '0;
            op_r             <= 2'b00;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        sign_1_r   <= sign_1;
                        sign_2_r   <= sign_2;
                        exp_r      <= exponent;
                        m1_r       <= mantissa_1;
                        m2_r       <= mantissa_2;
                        op_r       <= operator;
                        in_ready_r <= 1'b0;
                        if (operator == OP_MUL) begin
                            state_r <= MUL;
                        end else begin
                            state_r <= ADD;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ADD: begin
                    out_valid_r <= 1'b1;
                    state_r     <= DONE;
                    if (op_r == OP_RSV) begin
                        out_sign_r       <= 1'b0;
                        out_exponent_r   <= '0;
                        out_mantissa_r   <= '0;
                        out_invalid_op_r <= 1'b1;
                    end else begin
                        out_sign_r       <= add_sign_s;
                        out_exponent_r   <= {2'b00, exp_r};
                        out_mantissa_r   <= {add_res_s, {(MANT_W-1){1'b0}}};
                        out_invalid_op_r <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done_s) begin
                        out_valid_r      <= 1'b1;
                        out_sign_r       <= sign_1_r ^ sign_2_r;
                        out_exponent_r   <= {2'b00, exp_r} - (EXP_W+2)'(BIAS);
                        out_mantissa_r   <= mul_product_s;
                        out_invalid_op_r <= 1'b0;
                        state_r          <= DONE;
                    end else if (!mul_busy_s) begin
                        // Multiplier lost its operation; recover to accepting.
                        state_r    <= IDLE;
                        in_ready_r <= 1'b1;
                    end else begin
                        state_r <= MUL;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = out_valid_r;
    assign out_sign       = out_sign_r;
    assign out_exponent   = out_exponent_r;
    assign out_mantissa   = out_mantissa_r;
    assign out_invalid_op = out_invalid_op_r;

endmodule

// File: doc/fpu_execute.md
# fpu_execute

Mantissa-arithmetic stage of the FPU pipeline. It sits directly downstream of the align stage and consumes that stage's signs, shared exponent, aligned 24-bit mantissas and operator. It produces an un-normalized sign/exponent/48-bit mantissa result for the normalize stage. Add and subtract finish in one cycle; multiply runs as an iterative 24-cycle shift-add.

## Interface
- Parameters:
  - MANT_W, 24, mantissa width including the hidden bit.
  - EXP_W, 8, input exponent width.
  - BIAS, 127, exponent bias subtracted on multiply.
- Ports:
  - clk, input, 1, the single clock; all state changes on its rising edge.
  - rst_n, input, 1, reset, asynchronous and active-low.
  - in_valid, input, 1, upstream operand valid.
  - in_ready, output, 1, stage can accept an operand.
  - sign_1, sign_2, input, 1 each, operand signs.
  - exponent, input, EXP_W, shared exponent from align (e1 for add/sub, e1+e2 for multiply).
  - mantissa_1, mantissa_2, input, MANT_W each, 1.23 fixed point; mantissa_2 already aligned.
  - operator, input, 2, 00 add, 01 subtract, 10 multiply, 11 reserved.
  - out_valid, output, 1, result valid.
  - out_ready, input, 1, downstream accepts the result.
  - out_sign, output, 1, result sign.
  - out_exponent, output, EXP_W+2, signed two's-complement result exponent.
  - out_mantissa, output, 2*MANT_W, 2.46 fixed point.
  - out_invalid_op, output, 1, operator 11 was issued.

## Operation
- FSM states: IDLE, ADD, MUL, DONE.
- in_ready = (state == IDLE).
- Accept occurs when in_valid && in_ready. All inputs are captured into operand registers, so upstream may change them afterwards.
- Operators 00, 01 and 11 go IDLE->ADD. Operator 10 goes IDLE->MUL.
- ADD state:
  - Effective subtract when eff = sign_1 ^ sign_2 ^ (operator == 01).
  - eff = 0: mantissa sum = m1 + m2 (25 bits); sign = sign_1.
  - eff = 1 and m1 >= m2: diff = m1 - m2; sign = sign_1.
  - eff = 1 and m1 < m2: diff = m2 - m1; sign = sign_2 ^ (operator == 01).
  - Zero result forces sign 0.
  - out_mantissa = {sum/diff[24:0], 23'b0}, placing the result on the 2.46 grid.
  - out_exponent = zero-extended exponent.
  - Next state is DONE.
- MUL state:
  - Radix-2 shift-add with a 5-bit counter, exactly 24 iterations, LSB of multiplier first.
  - out_mantissa = m1 * m2 (exact 48 bits).
  - out_sign = sign_1 ^ sign_2.
  - out_exponent = {2'b00, exponent} - BIAS, 10-bit signed.
  - After the 24th iteration, next state is DONE.
- Operator 11: out_mantissa = 0, out_sign = 0, out_exponent = 0, out_invalid_op = 1; otherwise handled like ADD timing.
- DONE state:
  - out_valid = 1; all outputs are held stable.
  - When out_ready = 1, go to IDLE and clear out_valid.
- No accept is taken in DONE. in_valid is ignored whenever in_ready = 0.

## Timing
- Reset (async assert, sync release by design): state = IDLE, all outputs 0, in_ready = 1 after reset.
- Latency for add/sub/11: accept at edge T0; result registered and out_valid = 1 after T1.
- Latency for multiply: accept at T0; iterations on T1..T24; out_valid = 1 after T24.
- Handshake completes on the edge where out_valid && out_ready; in_ready = 1 after that edge.
- Throughput: one operation per 3 cycles (add) or 26 cycles (multiply) with out_ready held high.
- Backpressure: while out_ready = 0 in DONE, every output is frozen, indefinitely.
- Reset mid-operation aborts the operation: counter and operand registers clear, and no out_valid is produced.
- out_valid stays high until accepted. It is never deasserted without a handshake, except by reset.

## Structure
- Shared package fpu_pkg holds:
  - operator codes: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_RSV = 2'b11;
  - BIAS, MANT_W, EXP_W;
  - the execute state enum.
- Sub-module fpu_mul_seq holds the iterative multiplier: start, operands, busy/done, 48-bit product, 5-bit counter.
- ADD datapath and FSM stay in fpu_execute.

## Test plan
- Add 1.0+1.0: m1 = m2 = 0x800000, exponent = 127, op 00, signs 0 -> out_mantissa = 48'h8000_0000_0000, out_exponent = 127, sign 0, out_valid after T1.
- Subtract equal: 1.0-1.0 (op 01, equal operands) -> out_mantissa = 0, out_sign = 0.
- Effective subtract with m2 > m1: op 00, sign_1 = 0, sign_2 = 1, m1 = 0x800000, m2 = 0xC00000 -> mantissa field 0x400000 (48'h2000_0000_0000), out_sign = 1.
- Multiply 1.5*1.5: m1 = m2 = 0xC00000, exponent = 254, op 10 -> out_mantissa = 48'h9000_0000_0000, out_exponent = 127, out_valid exactly after T24.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE with in_valid = 1 -> outputs stable, in_ready = 0, second operand not accepted until the cycle after the handshake.
- Reset and reserved op:
  - Assert rst_n = 0 at iteration 10 of a multiply -> all outputs 0, state IDLE, no out_valid.
  - Then issue op 11 -> out_invalid_op = 1, out_mantissa = 0.
